// File: rtl/mmcm_drp_pkg.sv
// Shared types, DRP address map and divider encoding for the MMCM runtime reconfiguration controller.
package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        StRst,
        StIdle,
        StCheck,
        StHoldRst,
        StRd,
        StRdWait,
        StWr,
        StWrWait,
        StRelease,
        StWaitLock,
        StDone,
        StFail
    } state_e;

    typedef enum logic [1:0] {
        ErrNone  = 2'd0,
        ErrRange = 2'd1,
        ErrDrp   = 2'd2,
        ErrLock  = 2'd3
    } err_code_e;

    // Reg1 addresses; Reg2 of each counter sits at Reg1 + 1.
    localparam logic [6:0] AddrFbReg1      = 7'h14;
    localparam logic [6:0] AddrClkout0Reg1 = 7'h08;
    localparam logic [6:0] AddrClkout1Reg1 = 7'h0A;
    localparam logic [6:0] AddrClkout2Reg1 = 7'h0C;
    localparam logic [6:0] AddrClkout3Reg1 = 7'h0E;
    localparam logic [6:0] AddrClkout4Reg1 = 7'h10;
    localparam logic [6:0] AddrClkout5Reg1 = 7'h06;
    localparam logic [6:0] AddrClkout6Reg1 = 7'h12;

    localparam logic [15:0] Reg1Mask = 16'hF000;
    localparam logic [15:0] Reg2Mask = 16'hFF3F;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_sel;
        logic       no_count;
    } div_fields_t;

    function automatic div_fields_t div_encode(input logic [6:0] d);
        div_fields_t f;
        f = '0;
        if (d == 7'd1) begin
            f.high     = 6'd1;
            f.low      = 6'd1;
            f.no_count = 1'b1;
        end else begin
            f.high     = d[6:1];
            f.low      = 6'(d - {1'b0, d[6:1]});
            f.edge_sel = d[0];
        end
        return f;
    endfunction

    // List index k: pairs {Reg1, Reg2} for FB, then CLKOUT0..6.
    function automatic logic [6:0] reg_addr(input logic [3:0] k);
        logic [6:0] base;
        case (k[3:1])
            3'd0:    base = AddrFbReg1;
            3'd1:    base = AddrClkout0Reg1;
            3'd2:    base = AddrClkout1Reg1;
            3'd3:    base = AddrClkout2Reg1;
            3'd4:    base = AddrClkout3Reg1;
            3'd5:    base = AddrClkout4Reg1;
            3'd6:    base = AddrClkout5Reg1;
            default: base = AddrClkout6Reg1;
        endcase
        return base | {6'b0, k[0]};
    endfunction

endpackage

// File: rtl/mmcm_drp_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module mmcm_drp_timeout #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM runtime reconfiguration: holds the MMCM in reset, read-modify-writes the CLKFBOUT and
// CLKOUTn counter registers over DRP, then releases reset and waits for lock with timeout.
module mmcm_drp_reconfig
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned NUM_OUT      = 2,
    parameter int unsigned MULT_MIN     = 8,
    parameter int unsigned MULT_MAX     = 16,
    parameter int unsigned DRP_TIMEOUT  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [6:0]           cfg_mult_i,
    input  logic [7*NUM_OUT-1:0] cfg_div_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic                 locked_o,
    output logic                 mmcm_rst_o,
    input  logic                 mmcm_locked_i,
    output logic [6:0]           daddr_o,
    output logic [15:0]          di_o,
    input  logic [15:0]          do_i,
    output logic                 den_o,
    output logic                 dwe_o,
    input  logic                 drdy_i
);

    localparam int unsigned NumRegs = 2 * (NUM_OUT + 1);
    localparam logic [3:0]  LastIdx = 4'(NumRegs - 1);
    localparam int unsigned DrpW    = $clog2(DRP_TIMEOUT + 1);
    localparam int unsigned LockW   = $clog2(LOCK_TIMEOUT + 1);

    state_e                 state_q, state_d;
    err_code_e              err_code_q, fail_code;
    logic                   err_q;
    logic                   locked_q;
    logic [6:0]             cfg_mult_q;
    logic [7*NUM_OUT-1:0]   cfg_div_q;
    logic [3:0]             idx_q;
    logic [15:0]            wdata_q;
    logic [15:0]            rmw_data;
    logic [6:0]             cur_val;
    logic                   cfg_bad;
    logic                   accept;
    logic                   drp_expired;
    logic                   lock_expired;
    div_fields_t            enc;

    assign accept = (state_q == StIdle) && cfg_valid_i;

    mmcm_drp_timeout #(
        .Width (DrpW)
    ) u_drp_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     ((state_q == StRd) || (state_q == StWr)),
        .load_val (DrpW'(DRP_TIMEOUT - 1)),
        .en       ((state_q == StRdWait) || (state_q == StWrWait)),
        .expired  (drp_expired)
    );

    mmcm_drp_timeout #(
        .Width (LockW)
    ) u_lock_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (state_q == StRelease),
        .load_val (LockW'(LOCK_TIMEOUT - 1)),
        .en       (state_q == StWaitLock),
        .expired  (lock_expired)
    );

    always_comb begin
        cfg_bad = (cfg_mult_q < 7'(MULT_MIN)) || (cfg_mult_q > 7'(MULT_MAX));
        cur_val = cfg_mult_q;
        for (int n = 0; n < NUM_OUT; n++) begin
            if (cfg_div_q[7*n +: 7] == 7'd0) cfg_bad = 1'b1;
            if (int'(idx_q[3:1]) == n + 1) cur_val = cfg_div_q[7*n +: 7];
        end
        enc = div_encode(cur_val);
        if (!idx_q[0]) begin
            rmw_data = (do_i & Reg1Mask) | {4'b0, enc.high, enc.low};
        end else begin
            rmw_data = (do_i & Reg2Mask) | {8'b0, enc.edge_sel, enc.no_count, 6'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StRst;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        fail_code = ErrNone;
        case (state_q)
            StRst:     state_d = StIdle;
            StIdle:    if (cfg_valid_i) state_d = StCheck;
            StCheck: begin
                if (cfg_bad) begin
                    state_d   = StFail;
                    fail_code = ErrRange;
                end else begin
                    state_d = StHoldRst;
                end
            end
            StHoldRst: state_d = StRd;
            StRd:      state_d = StRdWait;
            StRdWait: begin
                if (drdy_i) begin
                    state_d = StWr;
                end else if (drp_expired) begin
                    state_d   = StFail;
                    fail_code = ErrDrp;
                end
            end
            StWr:      state_d = StWrWait;
            StWrWait: begin
                if (drdy_i) begin
                    state_d = (idx_q == LastIdx) ? StRelease : StRd;
                end else if (drp_expired) begin
                    state_d   = StFail;
                    fail_code = ErrDrp;
                end
            end
            StRelease: state_d = StWaitLock;
            StWaitLock: begin
                if (mmcm_locked_i) begin
                    state_d = StDone;
                end else if (lock_expired) begin
                    state_d   = StFail;
                    fail_code = ErrLock;
                end
            end
            StDone:    state_d = StIdle;
            StFail:    state_d = StIdle;
            default:   state_d = StRst;
        endcase
    end

    always_comb begin
        cfg_ready_o = (state_q == StIdle);
        busy_o      = (state_q != StIdle) && (state_q != StRst);
        done_o      = (state_q == StDone);
        den_o       = (state_q == StRd) || (state_q == StWr);
        dwe_o       = (state_q == StWr);
        daddr_o     = den_o ? reg_addr(idx_q) : 7'd0;
        di_o        = dwe_o ? wdata_q : 16'd0;
        mmcm_rst_o  = (state_q inside {StRst, StHoldRst, StRd, StRdWait, StWr, StWrWait});
        err_o       = err_q;
        err_code_o  = err_code_q;
        locked_o    = locked_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_mult_q <= '0;
            cfg_div_q  <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            locked_q   <= 1'b0;
        end else begin
            locked_q <= mmcm_locked_i && !mmcm_rst_o && !busy_o;
            if (accept) begin
                cfg_mult_q <= cfg_mult_i;
                cfg_div_q  <= cfg_div_i;
                idx_q      <= '0;
                err_q      <= 1'b0;
                err_code_q <= ErrNone;
            end
            if ((state_q == StRdWait) && drdy_i) wdata_q <= rmw_data;
            if ((state_q == StWrWait) && drdy_i && (idx_q != LastIdx)) idx_q <= idx_q + 1'b1;
            if (fail_code != ErrNone) begin
                err_q      <= 1'b1;
                err_code_q <= fail_code;
            end
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench: DRP register-file model, MMCM lock model and per-scenario checking tasks.
module tb_mmcm_drp_reconfig;

    localparam int unsigned NumOut   = 2;
    localparam int unsigned DrpTo    = 64;
    localparam int unsigned LockTo   = 100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [6:0]  cfg_mult_i = '0;
    logic [13:0] cfg_div_i = '0;
    logic        busy_o, done_o, err_o, locked_o, mmcm_rst_o;
    logic [1:0]  err_code_o;
    logic        mmcm_locked_i = 1'b0;
    logic [6:0]  daddr_o;
    logic [15:0] di_o;
    logic [15:0] do_i = '0;
    logic        den_o, dwe_o;
    logic        drdy_i = 1'b0;

    // Model controls, written only by the tasks.
    logic        drp_respond = 1'b1;
    logic        lock_en = 1'b1;
    int          lock_delay = 10;
    logic        fill_en = 1'b0;
    logic [15:0] fill_val = '0;

    logic [15:0] mem [128];
    int          wait_cnt = 0;
    int          lock_cnt = 0;

    int checks = 0;
    int fails = 0;

    // Monitor counters, written only by the monitor.
    int   cyc = 0;
    int   den_cnt = 0;
    int   done_cnt = 0;
    int   rst_hi_cnt = 0;
    int   last_den_cyc = 0;
    int   rst_fall_cyc = 0;
    logic rst_prev = 1'b0;

    always #5 clk = ~clk;

    mmcm_drp_reconfig #(
        .NUM_OUT      (NumOut),
        .MULT_MIN     (8),
        .MULT_MAX     (16),
        .DRP_TIMEOUT  (DrpTo),
        .LOCK_TIMEOUT (LockTo)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_mult_i    (cfg_mult_i),
        .cfg_div_i     (cfg_div_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .locked_o      (locked_o),
        .mmcm_rst_o    (mmcm_rst_o),
        .mmcm_locked_i (mmcm_locked_i),
        .daddr_o       (daddr_o),
        .di_o          (di_o),
        .do_i          (do_i),
        .den_o         (den_o),
        .dwe_o         (dwe_o),
        .drdy_i        (drdy_i)
    );

    // DRP model: drdy the cycle after den_o when enabled.
    always @(posedge clk) begin
        drdy_i <= 1'b0;
        if (fill_en) begin
            for (int i = 0; i < 128; i++) mem[i] <= fill_val;
        end
        if (den_o) begin
            if (dwe_o) mem[daddr_o] <= di_o;
            else       do_i <= mem[daddr_o];
            if (drp_respond) drdy_i <= 1'b1;
        end
        if (wait_cnt > 0) wait_cnt <= wait_cnt - 1;
    end

    // Lock model: LOCKED rises lock_delay cycles after RST falls.
    always @(posedge clk) begin
        if (mmcm_rst_o) begin
            lock_cnt      <= 0;
            mmcm_locked_i <= 1'b0;
        end else if (lock_en) begin
            if (lock_cnt >= lock_delay) mmcm_locked_i <= 1'b1;
            else                        lock_cnt <= lock_cnt + 1;
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (den_o) begin
            den_cnt      = den_cnt + 1;
            last_den_cyc = cyc;
        end
        if (done_o) done_cnt = done_cnt + 1;
        if (mmcm_rst_o) rst_hi_cnt = rst_hi_cnt + 1;
        if (rst_prev && !mmcm_rst_o) rst_fall_cyc = cyc;
        rst_prev = mmcm_rst_o;
    end

    task automatic fill(input logic [15:0] v);
        fill_val = v;
        fill_en  = 1'b1;
        @(negedge clk);
        fill_en  = 1'b0;
    endtask

    task automatic request(input logic [6:0] m, input logic [13:0] d);
        int n;
        cfg_mult_i  = m;
        cfg_div_i   = d;
        cfg_valid_i = 1'b1;
        n = 0;
        while (!cfg_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cfg_ready_o) begin
            fails++;
            $display("FAIL request_accept: ready=%0b required 1", cfg_ready_o);
        end
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        while (cycles < 2000 && !done_o && !err_o) begin
            @(negedge clk);
            cycles++;
        end
        if (!done_o && !err_o) begin
            checks++;
            fails++;
            $display("FAIL wait_end: no done/err within %0d cycles", cycles);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready_o, busy_o, done_o, err_o, err_code_o, locked_o, den_o, dwe_o} !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0", {cfg_ready_o, busy_o, done_o, err_o,
                     err_code_o, locked_o, den_o, dwe_o});
        end
        checks++;
        if ({daddr_o, di_o} !== 23'd0) begin
            fails++;
            $display("FAIL reset_drp: daddr=%h di=%h required 0", daddr_o, di_o);
        end
        checks++;
        if (mmcm_rst_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mmcm_rst: got %b required 1", mmcm_rst_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_ready_o !== 1'b1 || mmcm_rst_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_exit: ready=%b mmcm_rst=%b required 1/0", cfg_ready_o, mmcm_rst_o);
        end
    endtask

    task automatic test_basic;
        int cyc_n, den0, done0;
        fill(16'hFFFF);
        den0  = den_cnt;
        done0 = done_cnt;
        request(7'd12, {7'd12, 7'd3});
        wait_end(cyc_n);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done=%b err=%b required 1/0", done_o, err_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem[7'h14] !== 16'hF186 || mem[7'h15] !== 16'hFF3F) begin
            fails++;
            $display("FAIL basic_fb: reg1=%h reg2=%h required F186/FF3F", mem[7'h14], mem[7'h15]);
        end
        checks++;
        if (mem[7'h08] !== 16'hF042 || mem[7'h09] !== 16'hFFBF) begin
            fails++;
            $display("FAIL basic_clkout0: reg1=%h reg2=%h required F042/FFBF", mem[7'h08], mem[7'h09]);
        end
        checks++;
        if (mem[7'h0A] !== 16'hF186 || mem[7'h0B] !== 16'hFF3F) begin
            fails++;
            $display("FAIL basic_clkout1: reg1=%h reg2=%h required F186/FF3F", mem[7'h0A], mem[7'h0B]);
        end
        checks++;
        if (den_cnt - den0 != 12) begin
            fails++;
            $display("FAIL basic_den_count: got %0d required 12", den_cnt - den0);
        end
        checks++;
        if (done_cnt - done0 != 1) begin
            fails++;
            $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - done0);
        end
        checks++;
        if (locked_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_locked: locked=%b busy=%b required 1/0", locked_o, busy_o);
        end
    endtask

    task automatic test_range;
        int cyc_n, den0, rst0;
        den0 = den_cnt;
        rst0 = rst_hi_cnt;
        request(7'd20, {7'd4, 7'd4});
        wait_end(cyc_n);
        checks++;
        if (err_o !== 1'b1 || err_code_o !== 2'd1 || cyc_n > 3) begin
            fails++;
            $display("FAIL range_err: err=%b code=%0d after %0d cycles required 1/1 within 3",
                     err_o, err_code_o, cyc_n);
        end
        @(negedge clk);
        checks++;
        if (den_cnt != den0 || rst_hi_cnt != rst0) begin
            fails++;
            $display("FAIL range_untouched: den=%0d rst_hi=%0d required 0/0", den_cnt - den0,
                     rst_hi_cnt - rst0);
        end
        checks++;
        if (cfg_ready_o !== 1'b1 || err_o !== 1'b1) begin
            fails++;
            $display("FAIL range_idle: ready=%b err=%b required 1/1", cfg_ready_o, err_o);
        end
    endtask

    task automatic test_div_one;
        int cyc_n;
        fill(16'hA5A5);
        request(7'd8, {7'd5, 7'd1});
        wait_end(cyc_n);
        repeat (2) @(negedge clk);
        checks++;
        if (mem[7'h08][11:0] !== 12'h041 || mem[7'h09][7:6] !== 2'b01) begin
            fails++;
            $display("FAIL div1_fields: reg1=%h reg2=%h required x041/bits76=01", mem[7'h08], mem[7'h09]);
        end
        checks++;
        if (mem[7'h08] !== 16'hA041 || mem[7'h09] !== 16'hA565) begin
            fails++;
            $display("FAIL div1_mask: reg1=%h reg2=%h required A041/A565", mem[7'h08], mem[7'h09]);
        end
        checks++;
        if (mem[7'h14] !== 16'hA104 || mem[7'h15] !== 16'hA525) begin
            fails++;
            $display("FAIL div1_fb: reg1=%h reg2=%h required A104/A525", mem[7'h14], mem[7'h15]);
        end
        checks++;
        if (mem[7'h0A] !== 16'hA083 || mem[7'h0B] !== 16'hA5A5) begin
            fails++;
            $display("FAIL div1_clkout1: reg1=%h reg2=%h required A083/A5A5", mem[7'h0A], mem[7'h0B]);
        end
    endtask

    task automatic test_drp_timeout;
        int cyc_n, den0, dt;
        drp_respond = 1'b0;
        den0 = den_cnt;
        request(7'd10, {7'd4, 7'd4});
        wait_end(cyc_n);
        dt = cyc - last_den_cyc;
        checks++;
        if (err_code_o !== 2'd2 || dt < int'(DrpTo) || dt > int'(DrpTo) + 2) begin
            fails++;
            $display("FAIL drp_timeout: code=%0d after %0d cycles required 2 after %0d..%0d",
                     err_code_o, dt, DrpTo, DrpTo + 2);
        end
        checks++;
        if (den_cnt - den0 != 1) begin
            fails++;
            $display("FAIL drp_timeout_den: got %0d required 1", den_cnt - den0);
        end
        @(negedge clk);
        checks++;
        if (mmcm_rst_o !== 1'b0 || cfg_ready_o !== 1'b1 || done_cnt < 0) begin
            fails++;
            $display("FAIL drp_timeout_idle: mmcm_rst=%b ready=%b required 0/1", mmcm_rst_o, cfg_ready_o);
        end
        drp_respond = 1'b1;
    endtask

    task automatic test_lock_timeout;
        int cyc_n, dt;
        lock_en = 1'b0;
        request(7'd16, {7'd2, 7'd127});
        wait_end(cyc_n);
        dt = cyc - rst_fall_cyc;
        checks++;
        if (err_code_o !== 2'd3 || dt < int'(LockTo) || dt > int'(LockTo) + 2) begin
            fails++;
            $display("FAIL lock_timeout: code=%0d after %0d cycles required 3 after %0d..%0d",
                     err_code_o, dt, LockTo, LockTo + 2);
        end
        @(negedge clk);
        lock_en = 1'b1;
        request(7'd9, {7'd1, 7'd1});
        checks++;
        if (err_o !== 1'b0 || err_code_o !== 2'd0) begin
            fails++;
            $display("FAIL lock_err_clear: err=%b code=%0d required 0/0", err_o, err_code_o);
        end
        wait_end(cyc_n);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL lock_recover: done=%b err=%b required 1/0", done_o, err_o);
        end
    endtask

    task automatic test_reset_mid;
        int n, cyc_n;
        fill(16'hFFFF);
        request(7'd14, {7'd6, 7'd7});
        n = 0;
        while (!(den_o && !dwe_o && daddr_o == 7'h09) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(den_o && daddr_o == 7'h09)) begin
            fails++;
            $display("FAIL midrst_reach: daddr=%h den=%b required 09/1", daddr_o, den_o);
        end
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({cfg_ready_o, busy_o, done_o, err_o, err_code_o, locked_o, den_o, dwe_o,
             daddr_o, di_o} !== 32'd0 || mmcm_rst_o !== 1'b1) begin
            fails++;
            $display("FAIL midrst_outputs: den=%b dwe=%b busy=%b daddr=%h di=%h mmcm_rst=%b required reset values",
                     den_o, dwe_o, busy_o, daddr_o, di_o, mmcm_rst_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        request(7'd14, {7'd6, 7'd7});
        wait_end(cyc_n);
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_recover: done=%b err=%b required 1/0", done_o, err_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem[7'h14] !== 16'hF1C7 || mem[7'h08] !== 16'hF0C4 || mem[7'h09] !== 16'hFFBF ||
            mem[7'h0A] !== 16'hF0C3) begin
            fails++;
            $display("FAIL midrst_regs: fb=%h c0r1=%h c0r2=%h c1r1=%h required F1C7/F0C4/FFBF/F0C3",
                     mem[7'h14], mem[7'h08], mem[7'h09], mem[7'h0A]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_div_one();
        test_drp_timeout();
        test_lock_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
